// File: rtl/pc_thread_scheduler_pkg.sv
// Shared types and helpers for the barrel-fetch thread scheduler.
// Per-thread lifecycle states and the elaboration-time reset-vector helper.
package pc_sched_pkg;

  typedef longint unsigned u64_t;

  typedef enum logic [1:0] {
    T_IDLE     = 2'd0,
    T_READY    = 2'd1,
    T_INFLIGHT = 2'd2
  } thread_state_e;

  // Only ever evaluated with constant arguments, so no adder is built.
  function automatic u64_t reset_pc(input u64_t base, input u64_t stride, input int unsigned i);
    return base + stride * u64_t'(i);
  endfunction

endpackage

// File: rtl/pc_thread_scheduler_if.sv
// Fetch issue (valid/ready) and next-PC writeback bundle between the
// scheduler (master) and the fetch/execute pipeline (slave).
interface pc_thread_scheduler_if #(
  parameter int XLEN  = 32,
  parameter int TID_W = 3
);
  logic             fetch_valid;
  logic             fetch_ready;
  logic [TID_W-1:0] fetch_tid;
  logic [XLEN-1:0]  fetch_pc;
  logic             wb_valid;
  logic [TID_W-1:0] wb_tid;
  logic [XLEN-1:0]  wb_pc;

  modport master (
    output fetch_valid, fetch_tid, fetch_pc,
    input  fetch_ready,
    input  wb_valid, wb_tid, wb_pc
  );

  modport slave (
    input  fetch_valid, fetch_tid, fetch_pc,
    output fetch_ready,
    output wb_valid, wb_tid, wb_pc
  );
endinterface

// File: rtl/pc_thread_scheduler_rr_arbiter.sv
// Round-robin picker: first asserted request strictly after the pointer,
// wrapping around; the pointer's own slot is considered last.
module rr_arbiter #(
  parameter int NUM_THREADS = 5,
  parameter int TID_W       = 3
) (
  input  logic [NUM_THREADS-1:0] req,
  input  logic [TID_W-1:0]       ptr,
  output logic                   grant_valid,
  output logic [TID_W-1:0]       grant_idx
);

  int idx;

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_THREADS;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = TID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pc_thread_scheduler.sv
// Per-thread PC file and state tracker that issues {tid, pc} to fetch
// round-robin and absorbs next-PC writebacks from the pipeline.
module pc_thread_scheduler
  import pc_sched_pkg::*;
#(
  parameter int   NUM_THREADS = 5,
  parameter int   XLEN        = 32,
  parameter u64_t PC_BASE     = 0,
  parameter u64_t PC_STRIDE   = 400,
  parameter int   TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_THREADS-1:0]  thread_enable,
  input  logic                    clear,
  pc_thread_scheduler_if.master   bus,
  output logic                    wb_err
);

  thread_state_e          state_reg  [NUM_THREADS];
  thread_state_e          state_next [NUM_THREADS];
  logic [XLEN-1:0]        pc_reg     [NUM_THREADS];
  logic [NUM_THREADS-1:0] ready_mask;
  logic [NUM_THREADS-1:0] wb_hit;
  logic [NUM_THREADS-1:0] pick_hit;

  logic                   fetch_valid_reg;
  logic [TID_W-1:0]       fetch_tid_reg;
  logic [XLEN-1:0]        fetch_pc_reg;
  logic [TID_W-1:0]       ptr_reg;
  logic                   wb_err_reg;

  logic                   load_slot;
  logic                   pick_en;
  logic                   grant_valid;
  logic [TID_W-1:0]       grant_idx;
  logic [XLEN-1:0]        grant_pc;

  // The output slot refills when empty or draining; clear blocks any pick.
  assign load_slot = !fetch_valid_reg || bus.fetch_ready;
  assign pick_en   = load_slot && !clear && grant_valid;

  generate
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
      assign ready_mask[gi] = (state_reg[gi] == T_READY);
      assign wb_hit[gi]     = bus.wb_valid && !clear && (bus.wb_tid == TID_W'(gi))
                              && (state_reg[gi] == T_INFLIGHT);
      assign pick_hit[gi]   = pick_en && (grant_idx == TID_W'(gi));
    end
  endgenerate

  rr_arbiter #(
    .NUM_THREADS (NUM_THREADS),
    .TID_W       (TID_W)
  ) u_arb (
    .req         (ready_mask),
    .ptr         (ptr_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        state_reg[i] <= T_IDLE;
        pc_reg[i]    <= XLEN'(reset_pc(PC_BASE, PC_STRIDE, i));
      end
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        state_reg[i] <= state_next[i];
        if (wb_hit[i]) pc_reg[i] <= bus.wb_pc;
      end
    end
  end

  // A disabled in-flight thread keeps running until its writeback or a clear.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      state_next[i] = state_reg[i];
      case (state_reg[i])
        T_IDLE:     if (thread_enable[i]) state_next[i] = T_READY;
        T_READY: begin
          if (pick_hit[i])            state_next[i] = T_INFLIGHT;
          else if (!thread_enable[i]) state_next[i] = T_IDLE;
        end
        T_INFLIGHT: if (clear || wb_hit[i])
                      state_next[i] = thread_enable[i] ? T_READY : T_IDLE;
        default:    state_next[i] = T_IDLE;
      endcase
    end
  end

  always_comb begin
    grant_pc = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (grant_idx == TID_W'(i)) grant_pc = pc_reg[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid_reg <= 1'b0;
      fetch_tid_reg   <= '0;
      fetch_pc_reg    <= '0;
      ptr_reg         <= TID_W'(NUM_THREADS - 1);
    end else if (clear) begin
      fetch_valid_reg <= 1'b0;
    end else if (load_slot) begin
      fetch_valid_reg <= grant_valid;
      if (grant_valid) begin
        fetch_tid_reg <= grant_idx;
        fetch_pc_reg  <= grant_pc;
        ptr_reg       <= grant_idx;
      end
    end
  end

  // Covers both stale writebacks and out-of-range thread ids.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_err_reg <= 1'b0;
    end else if (bus.wb_valid && !clear && !(|wb_hit)) begin
      wb_err_reg <= 1'b1;
    end
  end

  assign bus.fetch_valid = fetch_valid_reg;
  assign bus.fetch_tid   = fetch_tid_reg;
  assign bus.fetch_pc    = fetch_pc_reg;
  assign wb_err          = wb_err_reg;

endmodule

// File: tb/tb_pc_thread_scheduler.sv
// Directed bench for pc_thread_scheduler: per-cycle vector tables for the
// issue/writeback flows plus hand sequences for clear, wb_err and reset.
module tb_pc_thread_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] thread_enable = 5'b11111;
  logic       clear = 1'b0;
  logic       wb_err;

  int n_checks = 0;
  int n_errors = 0;

  pc_thread_scheduler_if #(.XLEN(32), .TID_W(3)) bus ();

  pc_thread_scheduler #(
    .NUM_THREADS (5),
    .XLEN        (32),
    .PC_BASE     (0),
    .PC_STRIDE   (400)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .thread_enable (thread_enable),
    .clear         (clear),
    .bus           (bus.master),
    .wb_err        (wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  en;
    logic        rdy;
    logic        wbv;
    logic [2:0]  wbt;
    logic [31:0] wbpc;
    logic        ev;
    logic [2:0]  et;
    logic [31:0] epc;
    logic        eerr;
  } vec_t;

  vec_t tab_a [11];
  vec_t tab_b [23];

  function automatic vec_t mk(input logic [4:0] en, input logic rdy, input logic wbv,
                              input logic [2:0] wbt, input logic [31:0] wbpc,
                              input logic ev, input logic [2:0] et, input logic [31:0] epc,
                              input logic eerr);
    vec_t v;
    v.en = en; v.rdy = rdy; v.wbv = wbv; v.wbt = wbt; v.wbpc = wbpc;
    v.ev = ev; v.et = et; v.epc = epc; v.eerr = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] en, input logic rdy, input logic clr,
                       input logic wbv, input logic [2:0] wbt, input logic [31:0] wbpc);
    thread_enable   = en;
    bus.fetch_ready = rdy;
    clear           = clr;
    bus.wb_valid    = wbv;
    bus.wb_tid      = wbt;
    bus.wb_pc       = wbpc;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [2:0] et,
                            input logic [31:0] epc, input logic eerr);
    $display("[%0t] %s: fetch_valid=%0d tid=%0d pc=%0d wb_err=%0d",
             $time, tag, bus.fetch_valid, bus.fetch_tid, bus.fetch_pc, wb_err);
    check({tag, " valid"}, 32'(bus.fetch_valid), 32'(ev));
    if (ev) begin
      check({tag, " tid"}, 32'(bus.fetch_tid), 32'(et));
      check({tag, " pc"}, bus.fetch_pc, epc);
    end
    check({tag, " wb_err"}, 32'(wb_err), 32'(eerr));
  endtask

  task automatic do_reset();
    clear = 1'b0;
    bus.wb_valid = 1'b0;
    bus.fetch_ready = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Scenarios 1 and 2: all threads enabled, then two writebacks.
    tab_a[0]  = mk(5'h1F, 1, 0, 0, 0,   0, 0, 0,    0);
    tab_a[1]  = mk(5'h1F, 1, 0, 0, 0,   1, 0, 0,    0);
    tab_a[2]  = mk(5'h1F, 1, 0, 0, 0,   1, 1, 400,  0);
    tab_a[3]  = mk(5'h1F, 1, 0, 0, 0,   1, 2, 800,  0);
    tab_a[4]  = mk(5'h1F, 1, 0, 0, 0,   1, 3, 1200, 0);
    tab_a[5]  = mk(5'h1F, 1, 0, 0, 0,   1, 4, 1600, 0);
    tab_a[6]  = mk(5'h1F, 1, 0, 0, 0,   0, 0, 0,    0);
    tab_a[7]  = mk(5'h1F, 1, 1, 2, 804, 0, 0, 0,    0);
    tab_a[8]  = mk(5'h1F, 1, 1, 0, 4,   1, 2, 804,  0);
    tab_a[9]  = mk(5'h1F, 1, 0, 0, 0,   1, 0, 4,    0);
    tab_a[10] = mk(5'h1F, 1, 0, 0, 0,   0, 0, 0,    0);

    // Scenario 3 (stall on (1,400)) then scenario 4 (mask 10101, disable in flight).
    tab_b[0]  = mk(5'h1F, 1, 0, 0, 0,    0, 0, 0,    0);
    tab_b[1]  = mk(5'h1F, 1, 0, 0, 0,    1, 0, 0,    0);
    tab_b[2]  = mk(5'h1F, 1, 0, 0, 0,    1, 1, 400,  0);
    tab_b[3]  = mk(5'h1F, 0, 0, 0, 0,    1, 1, 400,  0);
    tab_b[4]  = mk(5'h1F, 0, 0, 0, 0,    1, 1, 400,  0);
    tab_b[5]  = mk(5'h1F, 0, 0, 0, 0,    1, 1, 400,  0);
    tab_b[6]  = mk(5'h1F, 1, 0, 0, 0,    1, 2, 800,  0);
    tab_b[7]  = mk(5'h1F, 1, 0, 0, 0,    1, 3, 1200, 0);
    tab_b[8]  = mk(5'h1F, 1, 0, 0, 0,    1, 4, 1600, 0);
    tab_b[9]  = mk(5'h1F, 1, 0, 0, 0,    0, 0, 0,    0);
    tab_b[10] = mk(5'h15, 1, 1, 0, 0,    0, 0, 0,    0);
    tab_b[11] = mk(5'h15, 1, 1, 1, 400,  1, 0, 0,    0);
    tab_b[12] = mk(5'h15, 1, 1, 2, 800,  0, 0, 0,    0);
    tab_b[13] = mk(5'h15, 1, 1, 3, 1200, 1, 2, 800,  0);
    tab_b[14] = mk(5'h15, 1, 1, 4, 1600, 0, 0, 0,    0);
    tab_b[15] = mk(5'h15, 1, 0, 0, 0,    1, 4, 1600, 0);
    tab_b[16] = mk(5'h15, 1, 1, 0, 8,    0, 0, 0,    0);
    tab_b[17] = mk(5'h15, 1, 0, 0, 0,    1, 0, 8,    0);
    tab_b[18] = mk(5'h11, 1, 1, 2, 808,  0, 0, 0,    0);
    tab_b[19] = mk(5'h11, 1, 0, 0, 0,    0, 0, 0,    0);
    tab_b[20] = mk(5'h15, 1, 0, 0, 0,    0, 0, 0,    0);
    tab_b[21] = mk(5'h15, 1, 0, 0, 0,    1, 2, 808,  0);
    tab_b[22] = mk(5'h15, 1, 0, 0, 0,    0, 0, 0,    0);

    bus.fetch_ready = 1'b1;
    bus.wb_valid    = 1'b0;
    bus.wb_tid      = '0;
    bus.wb_pc       = '0;

    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0);
    check("reset tid", 32'(bus.fetch_tid), 32'd0);
    check("reset pc", bus.fetch_pc, 32'd0);
    reset = 1'b1;

    for (int k = 0; k < 11; k++) begin
      drive(tab_a[k].en, tab_a[k].rdy, 1'b0, tab_a[k].wbv, tab_a[k].wbt, tab_a[k].wbpc);
      expect_out($sformatf("A%0d", k), tab_a[k].ev, tab_a[k].et, tab_a[k].epc, tab_a[k].eerr);
    end

    do_reset();
    for (int k = 0; k < 23; k++) begin
      drive(tab_b[k].en, tab_b[k].rdy, 1'b0, tab_b[k].wbv, tab_b[k].wbt, tab_b[k].wbpc);
      expect_out($sformatf("B%0d", k), tab_b[k].ev, tab_b[k].et, tab_b[k].epc, tab_b[k].eerr);
    end

    // Clear with threads 0 and 1 in flight and a same-cycle writeback.
    do_reset();
    drive(5'h03, 1, 0, 0, 0, 0);  expect_out("C0", 0, 0, 0, 0);
    drive(5'h03, 1, 0, 0, 0, 0);  expect_out("C1", 1, 0, 0, 0);
    drive(5'h03, 1, 0, 0, 0, 0);  expect_out("C2", 1, 1, 400, 0);
    drive(5'h03, 1, 1, 1, 0, 4);  expect_out("C3 clear", 0, 0, 0, 0);
    drive(5'h03, 1, 0, 0, 0, 0);  expect_out("C4 replay", 1, 0, 0, 0);
    drive(5'h03, 1, 0, 0, 0, 0);  expect_out("C5 replay", 1, 1, 400, 0);
    drive(5'h03, 1, 0, 0, 0, 0);  expect_out("C6", 0, 0, 0, 0);
    drive(5'h03, 1, 0, 1, 7, 5);  expect_out("C7 tid7", 0, 0, 0, 1);
    drive(5'h03, 1, 0, 1, 0, 4);  expect_out("C8 sticky", 0, 0, 0, 1);
    drive(5'h03, 1, 0, 0, 0, 0);  expect_out("C9", 1, 0, 4, 1);

    // Async reset mid-stream, with no clock edge before the check.
    reset = 1'b0;
    #2;
    expect_out("async reset", 0, 0, 0, 0);
    check("async reset tid", 32'(bus.fetch_tid), 32'd0);
    check("async reset pc", bus.fetch_pc, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(5'h1F, 1, 0, 0, 0, 0);  expect_out("R0", 0, 0, 0, 0);
    drive(5'h1F, 1, 0, 0, 0, 0);  expect_out("R1 pc0 vector", 1, 0, 0, 0);
    drive(5'h1F, 1, 0, 0, 0, 0);  expect_out("R2", 1, 1, 400, 0);

    // Writeback to a READY thread while the output slot is stalled.
    do_reset();
    drive(5'h09, 0, 0, 0, 0, 0);    expect_out("D0", 0, 0, 0, 0);
    drive(5'h09, 0, 0, 0, 0, 0);    expect_out("D1", 1, 0, 0, 0);
    drive(5'h09, 0, 0, 1, 3, 999);  expect_out("D2 wb ready", 1, 0, 0, 1);
    drive(5'h09, 0, 0, 0, 0, 0);    expect_out("D3 sticky", 1, 0, 0, 1);
    drive(5'h09, 1, 0, 0, 0, 0);    expect_out("D4 pc3 kept", 1, 3, 1200, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
